// File: rtl/blink_speed_ctrl.sv
// Pushbutton front-end for the blinker: debounces UP/DN/MODE and steps the speed level.
// It also selects the duty mode and publishes on_ms/off_ms with a one-cycle cfg_valid strobe.
module blink_speed_ctrl #(
    parameter int F_CLK_HZ       = 25_000_000,
    parameter int DEB_MS         = 20,
    parameter int HOLD_MS        = 600,
    parameter int REPEAT_MS      = 150,
    parameter int MAX_PERIOD_MS  = 1000,
    parameter int NUM_LEVELS     = 5,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_dn,
    input  logic        btn_mode,
    output logic [15:0] on_ms,
    output logic [15:0] off_ms,
    output logic [2:0]  level,
    output logic [1:0]  mode,
    output logic        cfg_valid
);

    localparam int TICKS_PER_MS = F_CLK_HZ / 1000;
    localparam int DEB_TICKS    = DEB_MS * TICKS_PER_MS;
    localparam int HOLD_TICKS   = HOLD_MS * TICKS_PER_MS;
    localparam int REPEAT_TICKS = REPEAT_MS * TICKS_PER_MS;
    localparam int REP_MAX      = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int DEB_W        = $clog2(DEB_TICKS + 1);
    localparam int REP_W        = $clog2(REP_MAX + 1);
    localparam logic [15:0] MAX_P   = 16'(MAX_PERIOD_MS);
    localparam logic [2:0]  TOP_LVL = 3'(NUM_LEVELS - 1);

    typedef enum logic [1:0] {
        MODE_SYM = 2'd0,
        MODE_D25 = 2'd1,
        MODE_D75 = 2'd2
    } mode_t;

    // Bit order: 0 = up, 1 = dn, 2 = mode
    logic [2:0] raw_pressed;
    logic [2:0] evt;

    assign raw_pressed = BTN_ACTIVE_LOW ? ~{btn_mode, btn_dn, btn_up}
                                        :  {btn_mode, btn_dn, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            localparam bit CAN_REPEAT = (gi != 2);

            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             press_reg;
            logic             rep_reg;
            logic             rep_phase_reg;
            logic [DEB_W-1:0] deb_cnt_reg;
            logic [REP_W-1:0] rep_cnt_reg;
            logic [REP_W-1:0] rep_limit;

            assign rep_limit = rep_phase_reg ? REP_W'(REPEAT_TICKS - 1) : REP_W'(HOLD_TICKS - 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg     <= 1'b0;
                    sync2_reg     <= 1'b0;
                    deb_reg       <= 1'b0;
                    press_reg     <= 1'b0;
                    rep_reg       <= 1'b0;
                    rep_phase_reg <= 1'b0;
                    deb_cnt_reg   <= '0;
                    rep_cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_pressed[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    rep_reg   <= 1'b0;

                    // Flip only after DEB_TICKS consecutive disagreeing samples
                    if (sync2_reg != deb_reg) begin
                        if (deb_cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
                            deb_cnt_reg <= '0;
                            deb_reg     <= sync2_reg;
                            press_reg   <= sync2_reg;
                        end else begin
                            deb_cnt_reg <= deb_cnt_reg + 1'b1;
                        end
                    end else begin
                        deb_cnt_reg <= '0;
                    end

                    // Counter runs from the press cycle; first period is the hold, then repeats
                    if (!deb_reg) begin
                        rep_cnt_reg   <= '0;
                        rep_phase_reg <= 1'b0;
                    end else if (rep_cnt_reg == rep_limit) begin
                        rep_cnt_reg   <= '0;
                        rep_phase_reg <= 1'b1;
                        rep_reg       <= CAN_REPEAT;
                    end else begin
                        rep_cnt_reg <= rep_cnt_reg + 1'b1;
                    end
                end
            end

            assign evt[gi] = press_reg | rep_reg;
        end
    endgenerate

    logic        up_evt;
    logic        dn_evt;
    logic        mode_evt;
    logic [2:0]  level_reg;
    logic [2:0]  level_next;
    mode_t       mode_reg;
    mode_t       mode_next;
    logic        chg_reg;
    logic [15:0] on_reg;
    logic [15:0] off_reg;
    logic        cfg_valid_reg;
    logic [15:0] period;
    logic [15:0] on_calc;
    logic [15:0] off_calc;

    assign up_evt   = evt[0];
    assign dn_evt   = evt[1];
    assign mode_evt = evt[2];

    always_comb begin
        level_next = level_reg;
        mode_next  = mode_reg;
        if (up_evt && !dn_evt && level_reg != TOP_LVL) begin
            level_next = level_reg + 3'd1;
        end else if (dn_evt && !up_evt && level_reg != 3'd0) begin
            level_next = level_reg - 3'd1;
        end
        if (mode_evt) begin
            case (mode_reg)
                MODE_SYM: mode_next = MODE_D25;
                MODE_D25: mode_next = MODE_D75;
                default:  mode_next = MODE_SYM;
            endcase
        end
    end

    always_comb begin
        period  = MAX_P >> level_reg;
        on_calc = period >> 1;
        case (mode_reg)
            MODE_D25: on_calc = period >> 2;
            MODE_D75: on_calc = period - (period >> 2);
            default:  on_calc = period >> 1;
        endcase
        off_calc = period - on_calc;
    end

    // chg_reg delays the strobe one cycle so on/off are computed from the updated level/mode
    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg     <= 3'd0;
            mode_reg      <= MODE_SYM;
            chg_reg       <= 1'b0;
            on_reg        <= MAX_P >> 1;
            off_reg       <= MAX_P - (MAX_P >> 1);
            cfg_valid_reg <= 1'b0;
        end else begin
            level_reg     <= level_next;
            mode_reg      <= mode_next;
            chg_reg       <= (level_next != level_reg) || (mode_next != mode_reg);
            cfg_valid_reg <= chg_reg;
            if (chg_reg) begin
                on_reg  <= on_calc;
                off_reg <= off_calc;
            end
        end
    end

    assign on_ms     = on_reg;
    assign off_ms    = off_reg;
    assign level     = level_reg;
    assign mode      = mode_reg;
    assign cfg_valid = cfg_valid_reg;

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// Randomized scoreboard bench for blink_speed_ctrl: a transaction-level model predicts strobes,
// and a monitor pops and compares them whenever cfg_valid fires.
module tb_blink_speed_ctrl;

    localparam int NL     = 5;
    localparam int HOLD_T = 100;   // 10 ms at 10 ticks/ms
    localparam int REP_T  = 50;    // 5 ms
    localparam int IDLE   = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up  = 1'b1;
    logic        dn  = 1'b1;
    logic        md  = 1'b1;
    logic [15:0] on_ms;
    logic [15:0] off_ms;
    logic [2:0]  level;
    logic [1:0]  mode;
    logic        cfg_valid;

    blink_speed_ctrl #(
        .F_CLK_HZ      (10_000),
        .DEB_MS        (2),
        .HOLD_MS       (10),
        .REPEAT_MS     (5),
        .MAX_PERIOD_MS (1000),
        .NUM_LEVELS    (NL),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (up),
        .btn_dn   (dn),
        .btn_mode (md),
        .on_ms    (on_ms),
        .off_ms   (off_ms),
        .level    (level),
        .mode     (mode),
        .cfg_valid(cfg_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int on;
        int off;
        int lvl;
        int md;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;
    int   m_level = 0;
    int   m_mode  = 0;
    int   txn_no  = 0;

    function automatic int period_of(int lvl);
        return 1000 / (1 << lvl);
    endfunction

    function automatic int on_of(int lvl, int md_v);
        int p = period_of(lvl);
        if (md_v == 1) return p / 4;
        if (md_v == 2) return p - p / 4;
        return p / 2;
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted configuration
    always @(negedge clk) begin
        if (!rst && cfg_valid) begin
            strobes++;
            if (q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_on", int'(on_ms), e.on);
                chk("strobe_off", int'(off_ms), e.off);
                chk("strobe_level", int'(level), e.lvl);
                chk("strobe_mode", int'(mode), e.md);
                chk("strobe_sum", int'(on_ms) + int'(off_ms), period_of(int'(level)));
            end
        end
    end

    task automatic check_state(string tag);
        chk({tag, "_level"}, int'(level), m_level);
        chk({tag, "_mode"}, int'(mode), m_mode);
        chk({tag, "_on"}, int'(on_ms), on_of(m_level, m_mode));
        chk({tag, "_off"}, int'(off_ms), period_of(m_level) - on_of(m_level, m_mode));
        chk({tag, "_missed_strobes"}, q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        m_level = 0;
        m_mode  = 0;
        @(negedge clk);
        chk("rst_cycle_valid", int'(cfg_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(cfg_valid), 0);
        chk("rst_on", int'(on_ms), 500);
        chk("rst_off", int'(off_ms), 500);
        chk("rst_level", int'(level), 0);
        chk("rst_mode", int'(mode), 0);
    endtask

    // Predict the events a hold of h cycles produces, then drive the buttons
    task automatic txn(bit u, bit d, bit m, int h);
        int  t;
        bit  chg;
        t = 0;
        while (t < h) begin
            chg = 1'b0;
            if (u && !d && m_level < NL - 1) begin
                m_level++;
                chg = 1'b1;
            end else if (d && !u && m_level > 0) begin
                m_level--;
                chg = 1'b1;
            end
            if (m && t == 0) begin
                m_mode = (m_mode + 1) % 3;
                chg = 1'b1;
            end
            if (chg) q.push_back('{on_of(m_level, m_mode),
                                   period_of(m_level) - on_of(m_level, m_mode),
                                   m_level, m_mode});
            if (!(u || d)) break;
            t = (t == 0) ? HOLD_T : t + REP_T;
        end
        @(posedge clk);
        #1;
        if (u) up = 1'b0;
        if (d) dn = 1'b0;
        if (m) md = 1'b0;
        repeat (h) @(posedge clk);
        #1;
        up = 1'b1;
        dn = 1'b1;
        md = 1'b1;
        repeat (IDLE) @(posedge clk);
        @(negedge clk);
        txn_no++;
        $display("txn %0d up=%0b dn=%0b mode=%0b hold=%0d -> level=%0d mode=%0d on=%0d off=%0d",
                 txn_no, u, d, m, h, level, mode, on_ms, off_ms);
        check_state("txn");
    endtask

    initial begin
        int s0;
        int hold_tab[4];
        hold_tab = '{50, 125, 175, 225};

        // 1: reset values
        repeat (2) @(posedge clk);
        do_reset();

        // 2: bounce, then a stable press gives exactly one strobe
        @(posedge clk);
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            #1 up = ~up;
            repeat (5) @(posedge clk);
        end
        txn(1'b1, 1'b0, 1'b0, 50);
        chk("t2_strobe_count", strobes - s0, 1);
        chk("t2_on", int'(on_ms), 250);
        chk("t2_off", int'(off_ms), 250);

        // 3: long hold saturates at level 4, then DN steps back to 3
        txn(1'b1, 1'b0, 1'b0, 300);
        chk("t3_level", int'(level), 4);
        chk("t3_on", int'(on_ms), 31);
        chk("t3_off", int'(off_ms), 31);
        txn(1'b0, 1'b1, 1'b0, 50);
        chk("t3_dn_on", int'(on_ms), 62);
        chk("t3_dn_off", int'(off_ms), 63);

        // 4: duty modes at level 0
        do_reset();
        txn(1'b0, 1'b0, 1'b1, 50);
        chk("t4_d25_on", int'(on_ms), 250);
        chk("t4_d25_off", int'(off_ms), 750);
        txn(1'b0, 1'b0, 1'b1, 50);
        chk("t4_d75_on", int'(on_ms), 750);
        chk("t4_d75_off", int'(off_ms), 250);

        // 5: UP and DN together cancel
        s0 = strobes;
        txn(1'b1, 1'b1, 1'b0, 50);
        chk("t5_strobe_count", strobes - s0, 0);

        // 6: reset lands mid-debounce; the short re-press after reset never completes
        @(posedge clk);
        #1 up = 1'b0;
        repeat (17) @(posedge clk);
        s0 = strobes;
        do_reset();
        repeat (5) @(posedge clk);
        #1 up = 1'b1;
        repeat (IDLE) @(posedge clk);
        @(negedge clk);
        chk("t6_strobe_count", strobes - s0, 0);
        check_state("t6");

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            int kind;
            int h;
            kind = int'($urandom_range(0, 4));
            h    = hold_tab[$urandom_range(0, 3)];
            case (kind)
                0: txn(1'b1, 1'b0, 1'b0, h);
                1: txn(1'b0, 1'b1, 1'b0, h);
                2: txn(1'b0, 1'b0, 1'b1, h);
                3: txn(1'b1, 1'b1, 1'b0, h);
                default: txn(1'b1, 1'b0, 1'b1, h);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
